// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, registered instruction/PC output with
// ready/valid handshake to decode, branch redirect, and halt-on-opcode.
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'd0,
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  input  logic        decode_ready,
  output logic [31:0] instr_out,
  output logic [7:0]  pc_out,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        load_s;

  function automatic logic is_halt(input logic [31:0] instr);
    return (instr[31:26] == HALT_OPCODE);
  endfunction

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

  assign load_s = (state_q == RUN) && (!valid_q || decode_ready) && !branch_taken;

  // Next-state: branch redirect beats load and stall; halt freezes the PC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (load_s) begin
          instr_d  = imem_instr;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          if (is_halt(imem_instr)) begin
            state_d = HALTED;
            pc_d    = pc_q;
          end else begin
            pc_d = pc_q + 8'd1;
          end
        end else begin
          valid_d = valid_q;
        end
      end
      HALTED: begin
        if (valid_q && decode_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      pc_out_q <= 8'h00;
      instr_q  <= 32'h0000_0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        decode_ready;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic        halted;

  logic [31:0] mem [256];
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        rst;
    logic        bt;
    logic [7:0]  tgt;
    logic        dr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [7:0]  e_pc;
    logic        e_halt;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t vecs[21];

  fetch_unit #(.RESET_PC(8'd0), .HALT_OPCODE(6'h3F)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .decode_ready (decode_ready),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .halted       (halted)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic bt, input logic [7:0] tg,
                              input logic d, input logic v, input logic [31:0] i,
                              input logic [7:0] p, input logic h, input logic [7:0] a);
    vec_t x;
    x.rst = r; x.bt = bt; x.tgt = tg; x.dr = d;
    x.e_valid = v; x.e_instr = i; x.e_pc = p; x.e_halt = h; x.e_addr = a;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v.e_valid});
    chk({tag, " instr_out"}, instr_out, v.e_instr);
    chk({tag, " pc_out"}, {24'd0, pc_out}, {24'd0, v.e_pc});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.e_halt});
    chk({tag, " imem_addr"}, {24'd0, imem_addr}, {24'd0, v.e_addr});
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    branch_taken  = v.bt;
    branch_target = v.tgt;
    decode_ready  = v.dr;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    reset         = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    decode_ready  = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = {8'h12, 16'h0000, 8'(a)};
    mem[0] = 32'h0000_0011;
    mem[1] = 32'h0000_0022;
    mem[2] = 32'h0000_0033;
    mem[3] = 32'h0000_0044;
    mem[4] = 32'h0000_0055;
    mem[8'h40] = 32'hFC00_0040;

    #2;
    check_outs("reset_state", mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00));

    // Streaming, reset, stall, branch, wrap, branch racing a halt fetch.
    vecs[0]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0011, 8'h00, 1'b0, 8'h01);
    vecs[1]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0022, 8'h01, 1'b0, 8'h02);
    vecs[2]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0033, 8'h02, 1'b0, 8'h03);
    vecs[3]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0044, 8'h03, 1'b0, 8'h04);
    vecs[4]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0055, 8'h04, 1'b0, 8'h05);
    vecs[5]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'h00);
    vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0011, 8'h00, 1'b0, 8'h01);
    vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0022, 8'h01, 1'b0, 8'h02);
    vecs[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_0022, 8'h01, 1'b0, 8'h02);
    vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_0022, 8'h01, 1'b0, 8'h02);
    vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_0022, 8'h01, 1'b0, 8'h02);
    vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0033, 8'h02, 1'b0, 8'h03);
    vecs[12] = mk(1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 32'h0000_0033, 8'h02, 1'b0, 8'h80);
    vecs[13] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h1200_0080, 8'h80, 1'b0, 8'h81);
    vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h1200_0081, 8'h81, 1'b0, 8'h82);
    vecs[15] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h1200_0081, 8'h81, 1'b0, 8'hFF);
    vecs[16] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h1200_00FF, 8'hFF, 1'b0, 8'h00);
    vecs[17] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0011, 8'h00, 1'b0, 8'h01);
    vecs[18] = mk(1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 32'h0000_0011, 8'h00, 1'b0, 8'h40);
    vecs[19] = mk(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 32'h0000_0011, 8'h00, 1'b0, 8'h10);
    vecs[20] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h1200_0010, 8'h10, 1'b0, 8'h11);

    for (int k = 0; k < 21; k++) step($sformatf("vec%0d", k), vecs[k]);

    // Halt at address 2, stall while halted, then accept; branches ignored.
    mem[2] = 32'hFC00_0000;
    step("h_rst",   mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00));
    step("h_f0",    mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0011, 8'h00, 1'b0, 8'h01));
    step("h_f1",    mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0022, 8'h01, 1'b0, 8'h02));
    step("h_halt",  mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'hFC00_0000, 8'h02, 1'b1, 8'h02));
    step("h_stall", mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'hFC00_0000, 8'h02, 1'b1, 8'h02));
    step("h_brst",  mk(1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 32'hFC00_0000, 8'h02, 1'b1, 8'h02));
    step("h_acc",   mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'hFC00_0000, 8'h02, 1'b1, 8'h02));
    step("h_br",    mk(1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 32'hFC00_0000, 8'h02, 1'b1, 8'h02));

    // Asynchronous reset between edges while halted with a pending instruction.
    step("a_rst",   mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00));
    step("a_f0",    mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0011, 8'h00, 1'b0, 8'h01));
    step("a_f1",    mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0022, 8'h01, 1'b0, 8'h02));
    step("a_halt",  mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'hFC00_0000, 8'h02, 1'b1, 8'h02));
    step("a_stall", mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'hFC00_0000, 8'h02, 1'b1, 8'h02));
    #1;
    reset = 1'b1;
    #1;
    check_outs("a_async", mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00));
    step("a_r0",    mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0011, 8'h00, 1'b0, 8'h01));
    step("a_r1",    mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_0022, 8'h01, 1'b0, 8'h02));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'd0, PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 6'h3F, opcode (instr[31:26]) that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  8  address to instruction_memory (combinational memory, same-cycle read).
REQ-006 imem_instr  input  32  instruction returned by instruction_memory for imem_addr.
REQ-007 branch_taken  input  1  redirect request from execute stage.
REQ-008 branch_target  input  8  redirect address, valid when branch_taken=1.
REQ-009 decode_ready  input  1  decode stage accepts instr_out this cycle.
REQ-010 instr_out  output  32  registered instruction to decode.
REQ-011 pc_out  output  8  address from which instr_out was fetched.
REQ-012 instr_valid  output  1  instr_out/pc_out hold a valid instruction.
REQ-013 halted  output  1  fetch stopped on HALT_OPCODE.

Function
REQ-014 Internal 8-bit PC register shall drive imem_addr directly (imem_addr = pc, no extra logic).
REQ-015 States: RUN, HALTED; halted=1 exactly when state is HALTED.
REQ-016 Load condition: load = state==RUN && (!instr_valid || decode_ready) && !branch_taken.
REQ-017 On load: instr_out<=imem_instr, pc_out<=pc, instr_valid<=1, pc<=pc+1 (8-bit, wraps 8'hFF -> 8'h00).
REQ-018 Latency: instruction at address A shall appear on instr_out one cycle after pc==A, with pc_out==A.
REQ-019 Handshake: transfer occurs when instr_valid && decode_ready; while instr_valid && !decode_ready, instr_out, pc_out, instr_valid and pc shall hold.
REQ-020 Back-to-back: with decode_ready held 1, one instruction per cycle, consecutive addresses.
REQ-021 Branch (state RUN, branch_taken=1): pc<=branch_target, instr_valid<=0, imem_instr that cycle discarded; branch overrides load and stall.
REQ-022 First instruction from branch_target shall be valid two cycles after the branch cycle (one bubble).
REQ-023 Halt: on a load whose imem_instr[31:26]==HALT_OPCODE, instruction is still presented (instr_valid=1) and state -> HALTED next edge; pc not incremented.
REQ-024 HALTED: no further loads; pc frozen; pending instr_out held until decode_ready, then instr_valid<=0; branch_taken ignored.
REQ-025 HALTED exits only via reset.
REQ-026 Branch in same cycle as a HALT_OPCODE fetch: branch wins, halt instruction discarded, state stays RUN.

Reset
REQ-027 reset=1 shall immediately (asynchronously) set pc=RESET_PC, instr_out=32'h0, pc_out=8'h0, instr_valid=0, state=RUN, halted=0.
REQ-028 Reset mid-operation (including stall or HALTED) shall discard pending instruction; first fetch after deassertion from RESET_PC, valid one cycle later.

Verification
REQ-029 Memory 0..4 = 32'h00000011..32'h00000055, decode_ready=1, release reset -> cycles 1..5 instr_out 11,22,33,44,55 with pc_out 0..4, instr_valid=1 each cycle.
REQ-030 decode_ready=0 for 3 cycles while instr_out=32'h22/pc_out=1 -> outputs and pc(=2) hold; on decode_ready=1 next output 32'h33/pc_out=2, no skip or duplicate.
REQ-031 branch_taken=1, branch_target=8'h80 while pc=3 -> next cycle instr_valid=0, pc=8'h80; following cycle instr_out=mem[8'h80], pc_out=8'h80.
REQ-032 Start at pc=8'hFF, decode_ready=1 -> pc_out 8'hFF then 8'h00 (wrap).
REQ-033 mem[2]=32'hFC000000 -> presented with pc_out=2, halted=1 next cycle, pc stays 2, instr_valid drops after accept; branch_taken then has no effect.
REQ-034 Assert reset asynchronously between clock edges while HALTED with instr_valid=1 -> outputs zero, halted=0 immediately; fetch resumes from RESET_PC.
